// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
// data_mem_pkg : I/O page address map, STATUS bit layout, page-select type
// Revision 1.0
// ============================================================================
package data_mem_pkg;

    localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_FF00;
    localparam logic [31:0] ADDR_STATUS = 32'hFFFF_FF01;
    localparam logic [31:0] ADDR_CYCLES = 32'hFFFF_FF02;

    localparam int STAT_EMPTY  = 0;
    localparam int STAT_FULL   = 1;
    localparam int STAT_CNT_LO = 2;
    localparam int STAT_CNT_HI = 7;
    localparam int STAT_OVF    = 8;

    typedef enum logic [2:0] {
        SEL_RAM  = 3'd0,
        SEL_TX   = 3'd1,
        SEL_STAT = 3'd2,
        SEL_CYC  = 3'd3,
        SEL_NONE = 3'd4
    } io_sel_e;

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_tx_fifo.sv
`default_nettype none
// ============================================================================
// tx_fifo : circular-buffer TX FIFO, push side from CPU, valid/ready drain
// Revision 1.0
// ============================================================================
module tx_fifo #(
    parameter int N          = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               push,
    input  logic [N-1:0]                       push_data,
    input  logic                               pop_ready,
    output logic                               valid,
    output logic [N-1:0]                       data,
    output logic                               full,
    output logic                               empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [N-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          pop;
    logic          wr_en;

    assign empty = (count == '0);
    assign full  = (count == CW'(FIFO_DEPTH));
    assign valid = !empty;
    assign pop   = pop_ready && !empty;
    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign wr_en = push && (!full || pop);
    assign data  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !pop) begin
                count <= count + CW'(1);
            end else if (!wr_en && pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// data_mem_responder : CPU data-memory responder, word RAM plus MMIO TX/STATUS/CYCLES
// Revision 1.0
// ============================================================================
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int N          = 32,
    parameter int RAM_DEPTH  = 1024,
    parameter int FIFO_DEPTH = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] address_i,
    input  logic [N-1:0] data_i,
    input  logic         we_i,
    output logic [N-1:0] data_o,
    output logic         tx_valid_o,
    output logic [N-1:0] tx_data_o,
    input  logic         tx_ready_i
);

    localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    io_sel_e       sel;
    logic [N-1:0]  ram [RAM_DEPTH];
    logic [N-1:0]  cycles;
    logic [N-1:0]  status;
    logic          overflow;
    logic          ovf_event;
    logic          ovf_clear;
    logic          tx_push;
    logic          tx_full;
    logic          tx_empty;
    logic [CW-1:0] tx_count;

    always_comb begin
        sel = SEL_NONE;
        if (address_i < N'(RAM_DEPTH)) begin
            sel = SEL_RAM;
        end else if (address_i == N'(ADDR_TXDATA)) begin
            sel = SEL_TX;
        end else if (address_i == N'(ADDR_STATUS)) begin
            sel = SEL_STAT;
        end else if (address_i == N'(ADDR_CYCLES)) begin
            sel = SEL_CYC;
        end
    end

    assign tx_push   = we_i && (sel == SEL_TX);
    assign ovf_event = tx_push && tx_full && !(tx_valid_o && tx_ready_i);
    assign ovf_clear = we_i && (sel == SEL_STAT) && data_i[STAT_OVF];

    tx_fifo #(
        .N          (N),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (tx_push),
        .push_data (data_i),
        .pop_ready (tx_ready_i),
        .valid     (tx_valid_o),
        .data      (tx_data_o),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    // RAM is deliberately outside the reset domain; writes are still blocked while in reset.
    always_ff @(posedge CLK) begin
        if (RST && we_i && (sel == SEL_RAM)) begin
            ram[address_i[AW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            overflow <= 1'b0;
            cycles   <= '0;
        end else begin
            if (ovf_event) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
            if (we_i && (sel == SEL_CYC)) begin
                cycles <= data_i;
            end else begin
                cycles <= cycles + 1'b1;
            end
        end
    end

    always_comb begin
        status                          = '0;
        status[STAT_EMPTY]              = tx_empty;
        status[STAT_FULL]               = tx_full;
        status[STAT_CNT_HI:STAT_CNT_LO] = 6'(tx_count);
        status[STAT_OVF]                = overflow;
    end

    always_comb begin
        data_o = '0;
        case (sel)
            SEL_RAM:  data_o = ram[address_i[AW-1:0]];
            SEL_STAT: data_o = status;
            SEL_CYC:  data_o = cycles;
            default:  data_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_data_mem_responder : directed stimulus with queued expectations and a monitor
// Revision 1.0
// ============================================================================
module tb_data_mem_responder;

    localparam logic [31:0] A_TX  = 32'hFFFF_FF00;
    localparam logic [31:0] A_ST  = 32'hFFFF_FF01;
    localparam logic [31:0] A_CYC = 32'hFFFF_FF02;

    logic        CLK;
    logic        RST;
    logic [31:0] address_i;
    logic [31:0] data_i;
    logic        we_i;
    logic [31:0] data_o;
    logic        tx_valid_o;
    logic [31:0] tx_data_o;
    logic        tx_ready_i;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } chk_t;

    chk_t        chkq[$];
    logic [31:0] txq[$];
    int          compared   = 0;
    int          mismatched = 0;

    data_mem_responder #(.N(32), .RAM_DEPTH(1024), .FIFO_DEPTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .address_i  (address_i),
        .data_i     (data_i),
        .we_i       (we_i),
        .data_o     (data_o),
        .tx_valid_o (tx_valid_o),
        .tx_data_o  (tx_data_o),
        .tx_ready_i (tx_ready_i)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // kind 0: data_o, 1: tx_valid_o, 2: tx_data_o
    always @(negedge CLK) begin
        chk_t        c;
        logic [31:0] got;
        logic [31:0] w;
        while (chkq.size() > 0) begin
            c = chkq.pop_front();
            case (c.kind)
                1:       got = {31'b0, tx_valid_o};
                2:       got = tx_data_o;
                default: got = data_o;
            endcase
            compared++;
            if (got !== c.exp) begin
                mismatched++;
                $display("FAIL %s: got %h expected %h", c.name, got, c.exp);
            end
        end
        if (tx_valid_o && tx_ready_i) begin
            compared++;
            if (txq.size() == 0) begin
                mismatched++;
                $display("FAIL tx_stream: got unexpected word %h expected nothing", tx_data_o);
            end else begin
                w = txq.pop_front();
                if (tx_data_o !== w) begin
                    mismatched++;
                    $display("FAIL tx_stream: got %h expected %h", tx_data_o, w);
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_v(input string name, input int kind, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.kind = kind;
        c.exp  = exp;
        chkq.push_back(c);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        address_i = a;
        data_i    = d;
        we_i      = 1'b1;
        step();
        we_i      = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input string name, input logic [31:0] exp);
        address_i = a;
        we_i      = 1'b0;
        expect_v(name, 0, exp);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST        = 1'b0;
        address_i  = 32'h0;
        data_i     = 32'h0;
        we_i       = 1'b0;
        tx_ready_i = 1'b0;
        step();
        expect_v("reset_txvalid", 1, 32'h0);
        expect_v("reset_txdata", 2, 32'h0);
        rd(A_ST, "reset_status", 32'h1);
        rd(A_CYC, "reset_cycles", 32'h0);
        RST = 1'b1;

        // RAM
        wr(32'd5, 32'hDEAD_BEEF);
        rd(32'd5, "ram5", 32'hDEAD_BEEF);
        rd(32'h0000_2000, "unmapped", 32'h0);
        wr(32'd0, 32'h0000_1234);
        wr(32'd1023, 32'hCAFE_F00D);
        wr(32'd1024, 32'h5555_5555);
        rd(32'd1023, "ram_top", 32'hCAFE_F00D);
        rd(32'd1024, "ram_past_end", 32'h0);
        rd(32'd0, "ram0_no_alias", 32'h0000_1234);

        // FIFO fill then drain
        wr(A_TX, 32'h11); txq.push_back(32'h11);
        wr(A_TX, 32'h22); txq.push_back(32'h22);
        wr(A_TX, 32'h33); txq.push_back(32'h33);
        expect_v("tx_head_11", 2, 32'h11);
        expect_v("tx_valid_3", 1, 32'h1);
        rd(A_ST, "status_3", 32'h0000_000C);
        rd(A_TX, "txdata_read0", 32'h0);
        expect_v("tx_head_nopop", 2, 32'h11);
        rd(A_ST, "status_3_again", 32'h0000_000C);
        tx_ready_i = 1'b1;
        repeat (3) step();
        expect_v("tx_drained", 1, 32'h0);
        rd(A_ST, "status_empty", 32'h1);
        tx_ready_i = 1'b0;

        // overflow
        for (int i = 0; i < 9; i++) begin
            wr(A_TX, 32'h100 + i);
            if (i < 8) txq.push_back(32'h100 + i);
        end
        expect_v("tx_head_100", 2, 32'h100);
        rd(A_ST, "status_ovf", 32'h0000_0122);
        wr(A_ST, 32'h0000_00FF);
        rd(A_ST, "status_noclear", 32'h0000_0122);
        wr(A_ST, 32'h0000_0100);
        rd(A_ST, "status_cleared", 32'h0000_0022);

        // push into full FIFO with a same-cycle pop
        tx_ready_i = 1'b1;
        wr(A_TX, 32'hAA); txq.push_back(32'hAA);
        tx_ready_i = 1'b0;
        rd(A_ST, "status_full_pushpop", 32'h0000_0022);
        tx_ready_i = 1'b1;
        repeat (8) step();
        tx_ready_i = 1'b0;
        expect_v("tx_drained_aa", 1, 32'h0);
        rd(A_ST, "status_empty2", 32'h1);

        // cycle counter wrap
        wr(A_CYC, 32'hFFFF_FFFE);
        rd(A_CYC, "cyc_fe", 32'hFFFF_FFFE);
        rd(A_CYC, "cyc_ff", 32'hFFFF_FFFF);
        rd(A_CYC, "cyc_wrap", 32'h0);

        // asynchronous reset mid-drain
        for (int i = 0; i < 4; i++) begin
            wr(A_TX, 32'h200 + i);
            txq.push_back(32'h200 + i);
        end
        tx_ready_i = 1'b1;
        step();
        #2;
        RST = 1'b0;
        txq.delete();
        address_i = A_ST;
        expect_v("rst_txvalid_async", 1, 32'h0);
        expect_v("rst_txdata_async", 2, 32'h0);
        expect_v("rst_status_async", 0, 32'h1);
        step();
        rd(A_CYC, "rst_cycles", 32'h0);
        wr(32'd5, 32'h0);
        rd(32'd5, "rst_ram5_kept", 32'hDEAD_BEEF);
        tx_ready_i = 1'b0;
        RST = 1'b1;
        rd(A_CYC, "cyc_after_rst0", 32'h0);
        rd(A_CYC, "cyc_after_rst1", 32'h1);
        rd(A_ST, "status_after_rst", 32'h1);

        step();
        compared++;
        if (txq.size() != 0) begin
            mismatched++;
            $display("FAIL tx_leftover: got %0d pending words expected 0", txq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
